// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage: reset PC, instruction size,
// bubble encoding and the run-control FSM state.
package fetch_pkg;

  localparam int unsigned PC_RESET    = 0;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] BUBBLE      = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/flopre.sv
// Register with async active-high reset, synchronous clear and load enable.
// Clear takes priority over enable; reset and clear both load RST_VAL.
module flopre #(
  parameter int unsigned    W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= RST_VAL;
    else if (clr) q <= RST_VAL;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with redirect/stall, instruction-memory
// word address, and the IF/ID pipeline register with stall/flush.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned N  = 64,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          PCSrc_F,
  input  logic [N-1:0]  PCBranch_F,
  input  logic          Stall_F,
  input  logic          Flush_D,
  input  logic [31:0]   q_F,
  output logic [AW-1:0] imem_addr_F,
  output logic [N-1:0]  PC_F,
  output logic [31:0]   instr_D,
  output logic [N-1:0]  PC_D,
  output logic          valid_D
);

  localparam int unsigned DW = 32 + N + 1;
  localparam logic [DW-1:0] IFID_RST = {BUBBLE, N'(PC_RESET), 1'b0};

  state_t          state, state_n;
  logic            pc_en;
  logic            ifid_en;
  logic            ifid_clr;
  logic [N-1:0]    pc_next;
  logic [DW-1:0]   ifid_d;
  logic [DW-1:0]   ifid_q;
  logic            unused_branch_lsbs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // IDLE spends one edge with all controls masked, then RUN until reset.
  always_comb begin
    state_n  = state;
    pc_en    = 1'b0;
    ifid_en  = 1'b0;
    ifid_clr = 1'b0;
    case (state)
      IDLE: state_n = RUN;
      RUN: begin
        pc_en    = PCSrc_F | ~Stall_F;
        ifid_en  = ~Stall_F;
        ifid_clr = Flush_D;
      end
      default: state_n = IDLE;
    endcase
  end

  // Redirect wins over stall; targets are forced word-aligned.
  always_comb begin
    pc_next = PC_F + N'(INSTR_BYTES);
    if (PCSrc_F) pc_next = {PCBranch_F[N-1:2], 2'b00};
  end

  assign unused_branch_lsbs = ^PCBranch_F[1:0];

  flopre #(.W(N), .RST_VAL(N'(PC_RESET))) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .clr   (1'b0),
    .d     (pc_next),
    .q     (PC_F)
  );

  assign imem_addr_F = PC_F[AW+1:2];
  assign ifid_d      = {q_F, PC_F, 1'b1};

  flopre #(.W(DW), .RST_VAL(IFID_RST)) u_ifid_reg (
    .clk   (clk),
    .reset (reset),
    .en    (ifid_en),
    .clr   (ifid_clr),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign {instr_D, PC_D, valid_D} = ifid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized redirect/stall/flush/reset traffic against a behavioural model.
module tb_fetch_stage;

  localparam int unsigned N  = 64;
  localparam int unsigned AW = 6;

  logic          clk;
  logic          reset;
  logic          PCSrc_F;
  logic [N-1:0]  PCBranch_F;
  logic          Stall_F;
  logic          Flush_D;
  logic [31:0]   q_F;
  logic [AW-1:0] imem_addr_F;
  logic [N-1:0]  PC_F;
  logic [31:0]   instr_D;
  logic [N-1:0]  PC_D;
  logic          valid_D;

  int n_chk;
  int n_fail;

  // Reference model state
  bit          m_run;
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] m_pcd;
  logic        m_valid;

  fetch_stage #(.N(N), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCSrc_F     (PCSrc_F),
    .PCBranch_F  (PCBranch_F),
    .Stall_F     (Stall_F),
    .Flush_D     (Flush_D),
    .q_F         (q_F),
    .imem_addr_F (imem_addr_F),
    .PC_F        (PC_F),
    .instr_D     (instr_D),
    .PC_D        (PC_D),
    .valid_D     (valid_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_pc    = 64'd0;
    m_instr = 32'd0;
    m_pcd   = 64'd0;
    m_valid = 1'b0;
  endtask

  // One rising edge of the fetch stage, evaluated from the current inputs.
  task automatic model_edge();
    logic [63:0] old_pc;
    old_pc = m_pc;
    if (!m_run) begin
      m_run = 1'b1;
    end else begin
      if (Flush_D) begin
        m_instr = 32'd0; m_pcd = 64'd0; m_valid = 1'b0;
      end else if (!Stall_F) begin
        m_instr = q_F; m_pcd = old_pc; m_valid = 1'b1;
      end
      if (PCSrc_F)       m_pc = PCBranch_F & ~64'd3;
      else if (!Stall_F) m_pc = old_pc + 64'd4;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".PC_F"},    PC_F,               m_pc);
    check({tag, ".imem"},    64'(imem_addr_F),   64'((m_pc / 4) % 64));
    check({tag, ".instr_D"}, 64'(instr_D),       64'(m_instr));
    check({tag, ".PC_D"},    PC_D,               m_pcd);
    check({tag, ".valid_D"}, 64'(valid_D),       64'(m_valid));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".PC_F"},    PC_F,             64'd0);
    check({tag, ".imem"},    64'(imem_addr_F), 64'd0);
    check({tag, ".instr_D"}, 64'(instr_D),     64'd0);
    check({tag, ".PC_D"},    PC_D,             64'd0);
    check({tag, ".valid_D"}, 64'(valid_D),     64'd0);
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic mid_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_zero(tag);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drive(input logic src, input logic [63:0] br, input logic st, input logic fl);
    PCSrc_F    = src;
    PCBranch_F = br;
    Stall_F    = st;
    Flush_D    = fl;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    q_F = 32'hf800_0001;
    model_reset();
    #2;
    check_zero("reset");

    @(negedge clk);
    reset = 1'b0;

    // Idle edge, then first fetched instruction
    step("idle");
    check("idle.PC_F_lit", PC_F, 64'd0);
    check("idle.valid_lit", 64'(valid_D), 64'd0);
    step("first");
    check("first.instr_lit", 64'(instr_D), 64'hf800_0001);
    check("first.PC_D_lit", PC_D, 64'd0);
    check("first.PC_F_lit", PC_F, 64'd4);
    check("first.imem_lit", 64'(imem_addr_F), 64'd1);

    // Free run
    step("run1");
    check("run1.PC_D_lit", PC_D, 64'd4);
    check("run1.imem_lit", 64'(imem_addr_F), 64'd2);
    step("run2");
    check("run2.PC_D_lit", PC_D, 64'd8);
    check("run2.imem_lit", 64'(imem_addr_F), 64'd3);

    // Redirect overrides stall; IF/ID holds
    drive(1'b1, 64'h43, 1'b1, 1'b0);
    step("redir_stall");
    check("redir_stall.PC_F_lit", PC_F, 64'h40);
    check("redir_stall.imem_lit", 64'(imem_addr_F), 64'd16);
    check("redir_stall.PC_D_lit", PC_D, 64'd8);

    // Stall two cycles at 0x10
    drive(1'b1, 64'h10, 1'b0, 1'b0);
    step("to_10");
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    step("stall1");
    step("stall2");
    check("stall2.PC_F_lit", PC_F, 64'h10);
    check("stall2.PC_D_lit", PC_D, 64'h40);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    step("unstall");
    check("unstall.PC_F_lit", PC_F, 64'h14);

    // Flush overrides stall
    drive(1'b0, 64'h0, 1'b1, 1'b1);
    step("flush_stall");
    check("flush_stall.valid_lit", 64'(valid_D), 64'd0);
    check("flush_stall.PC_F_lit", PC_F, 64'h14);

    // Word-address wrap
    drive(1'b1, 64'hFC, 1'b0, 1'b0);
    step("to_fc");
    check("to_fc.imem_lit", 64'(imem_addr_F), 64'd63);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    step("wrap");
    check("wrap.PC_F_lit", PC_F, 64'h100);
    check("wrap.imem_lit", 64'(imem_addr_F), 64'd0);

    // Reset mid-cycle while redirect and stall are pending
    drive(1'b1, 64'h80, 1'b1, 1'b0);
    mid_reset("midreset");
    drive(1'b0, 64'h0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [63:0] br;
      br = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) br = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      q_F = $urandom;
      drive(($urandom_range(0, 5) == 0), br, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0));
      step($sformatf("rnd%0d", i));
      if ($urandom_range(0, 99) == 0) mid_reset($sformatf("rnd_reset%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
